// File: rtl/lvds_frame_gen_if.sv
// Run controls and framed lane outputs of lvds_frame_gen.
// The generator connects through master; whatever consumes the frames connects through slave.
interface lvds_frame_gen_if #(
  parameter int LANES  = 2,
  parameter int DATA_W = 8
) ();
  logic                    enable;
  logic [1:0]              mode;
  logic [DATA_W-1:0]       fixed_pat;
  logic [LANES*DATA_W-1:0] lane_data;
  logic                    sync;
  logic                    valid;
  logic                    frame_last;
  logic [15:0]             frame_cnt;

  modport master (
    input  enable, mode, fixed_pat,
    output lane_data, sync, valid, frame_last, frame_cnt
  );

  modport slave (
    output enable, mode, fixed_pat,
    input  lane_data, sync, valid, frame_last, frame_cnt
  );
endinterface

// File: rtl/lvds_frame_gen.sv
// Multi-lane framed test-pattern source for the LVDS serialiser path.
// Each frame is one sync word, FRAME_LEN payload words, then GAP_LEN idle words.
module lvds_frame_gen #(
  parameter int          LANES     = 2,
  parameter int          DATA_W    = 8,
  parameter int          FRAME_LEN = 256,
  parameter int          GAP_LEN   = 16,
  parameter int unsigned SYNC_WORD = 32'h0000_00A5,
  parameter int unsigned IDLE_WORD = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  lvds_frame_gen_if.master bus
);
  localparam logic [15:0]       LAST_IDX = 16'(FRAME_LEN - 1);
  localparam logic [15:0]       LAST_GAP = 16'(GAP_LEN - 1);
  localparam logic [DATA_W-1:0] SYNC_W   = DATA_W'(SYNC_WORD);
  localparam logic [DATA_W-1:0] IDLE_W   = DATA_W'(IDLE_WORD);
  localparam int unsigned       DW_U     = DATA_W;

  typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_e;

  state_e                  state_q, state_d;
  logic [15:0]             idx_q, idx_d;
  logic [15:0]             gap_q, gap_d;
  logic [1:0]              mode_q, mode_d;
  logic [DATA_W-1:0]       fixed_q, fixed_d;
  logic [15:0]             lfsr_q [LANES];
  logic [15:0]             lfsr_d [LANES];
  logic [LANES*DATA_W-1:0] lane_data_q, lane_data_d;
  logic                    sync_q, sync_d;
  logic                    valid_q, valid_d;
  logic                    frame_last_q, frame_last_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;

  function automatic logic [15:0] lfsr_seed(input int k);
    return 16'hACE1 + 16'(k);
  endfunction

  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting towards bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic [DATA_W-1:0] payload_word(
    input int                k,
    input logic [15:0]       idx,
    input logic [1:0]        md,
    input logic [DATA_W-1:0] fixed,
    input logic [15:0]       lfsr
  );
    logic [15:0] cnt_word;
    int unsigned bit_pos;
    cnt_word = idx * 16'(LANES) + 16'(k);
    bit_pos  = (32'(idx) + 32'(k)) % DW_U;
    case (md)
      2'd0:    payload_word = cnt_word[DATA_W-1:0];
      2'd1:    payload_word = lfsr[DATA_W-1:0];
      2'd2:    payload_word = fixed;
      default: payload_word = DATA_W'(1) << bit_pos;
    endcase
  endfunction

  // Output registers are loaded from the current state, so every output trails the state by one cycle.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    mode_d       = mode_q;
    fixed_d      = fixed_q;
    lfsr_d       = lfsr_q;
    frame_cnt_d  = frame_cnt_q;
    lane_data_d  = {LANES{IDLE_W}};
    sync_d       = 1'b0;
    valid_d      = 1'b0;
    frame_last_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable) state_d = SYNC;
      end
      SYNC: begin
        sync_d      = 1'b1;
        lane_data_d = {LANES{SYNC_W}};
        mode_d      = bus.mode;
        fixed_d     = bus.fixed_pat;
        idx_d       = '0;
        for (int k = 0; k < LANES; k++) lfsr_d[k] = lfsr_seed(k);
        state_d     = DATA;
      end
      DATA: begin
        valid_d = 1'b1;
        for (int k = 0; k < LANES; k++) begin
          lane_data_d[k*DATA_W +: DATA_W] = payload_word(k, idx_q, mode_q, fixed_q, lfsr_q[k]);
          lfsr_d[k] = lfsr_next(lfsr_q[k]);
        end
        idx_d = idx_q + 16'd1;
        if (idx_q == LAST_IDX) begin
          frame_last_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
          if (GAP_LEN == 0) begin
            state_d = bus.enable ? SYNC : IDLE;
          end else begin
            state_d = GAP;
            gap_d   = '0;
          end
        end
      end
      GAP: begin
        gap_d = gap_q + 16'd1;
        if (gap_q == LAST_GAP) state_d = bus.enable ? SYNC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      gap_q        <= '0;
      mode_q       <= '0;
      fixed_q      <= '0;
      for (int k = 0; k < LANES; k++) lfsr_q[k] <= lfsr_seed(k);
      lane_data_q  <= {LANES{IDLE_W}};
      sync_q       <= 1'b0;
      valid_q      <= 1'b0;
      frame_last_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      mode_q       <= mode_d;
      fixed_q      <= fixed_d;
      lfsr_q       <= lfsr_d;
      lane_data_q  <= lane_data_d;
      sync_q       <= sync_d;
      valid_q      <= valid_d;
      frame_last_q <= frame_last_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign bus.lane_data  = lane_data_q;
  assign bus.sync       = sync_q;
  assign bus.valid      = valid_q;
  assign bus.frame_last = frame_last_q;
  assign bus.frame_cnt  = frame_cnt_q;
endmodule
